// File: rtl/conveyor_pkg.sv
// conveyor_pkg: fault codes, conveyor slot layout and width helper shared by the write arbiter.
package conveyor_pkg;
    localparam int FAULT_ADDR_WIDTH = 4;
    localparam int WORD_WIDTH_DEF = 32;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE    = 4'd0;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_ALIGN   = 4'd1;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_ACCESS  = 4'd2;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_ILLEGAL = 4'd3;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_PAGE    = 4'd4;
    typedef struct packed {
        logic                        finished;
        logic [FAULT_ADDR_WIDTH-1:0] fault;
        logic [WORD_WIDTH_DEF-1:0]   value;
    } conveyor_slot_t;
    function automatic int conveyor_width(input int word_width);
        return 1 + FAULT_ADDR_WIDTH + word_width;
    endfunction
endpackage

// File: rtl/conveyor_write_arbiter_if.sv
// conveyor_write_arbiter_if: requester results, port_busy and the conveyor write port.
interface conveyor_write_arbiter_if
    import conveyor_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]                                req_valid;
    logic [REQUESTERS-1:0]                                req_ready;
    logic [REQUESTERS-1:0]                                req_conveyor;
    logic [REQUESTERS-1:0][CONVEYOR_ADDR_WIDTH-1:0]       req_slot;
    logic [REQUESTERS-1:0][WORD_WIDTH-1:0]                req_value;
    logic [REQUESTERS-1:0][FAULT_ADDR_WIDTH-1:0]          req_fault;
    logic [1:0]                                           port_busy;
    logic                                                 wr_en;
    logic                                                 wr_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0]                       wr_slot;
    logic [conveyor_width(WORD_WIDTH)-1:0]                wr_data;
    logic                                                 idle;
    modport master (
        output req_valid, req_conveyor, req_slot, req_value, req_fault, port_busy,
        input  req_ready, wr_en, wr_conveyor, wr_slot, wr_data, idle
    );
    modport slave (
        input  req_valid, req_conveyor, req_slot, req_value, req_fault, port_busy,
        output req_ready, wr_en, wr_conveyor, wr_slot, wr_data, idle
    );
endinterface

// File: rtl/conveyor_rr_pick.sv
// conveyor_rr_pick: first set bit of valid at or after ptr, cyclically, as one-hot and index.
module conveyor_rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    int j;
    always_comb begin
        idx = '0;
        any = 1'b0;
        j = 0;
        // Scan from farthest to nearest so the nearest valid slot is the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (valid[j]) begin
                idx = PW'(j);
                any = 1'b1;
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/conveyor_write_arbiter.sv
// conveyor_write_arbiter: round-robin result-write arbiter with a one-entry stage yielding to port_busy.
// CONVEYOR_ARB_FAULT_EN: when defined, req_fault is captured into the wr_data fault field.
module conveyor_write_arbiter
    import conveyor_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int REQUESTERS = 4
) (
    input logic clk,
    input logic reset,
    conveyor_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(REQUESTERS);
    logic [PW-1:0]                  rr_ptr_q, rr_ptr_d, pick_idx;
    logic [REQUESTERS-1:0]          pick_grant;
    logic                           pick_any;
    logic                           out_valid_q, out_valid_d;
    logic                           out_conveyor_q, out_conveyor_d;
    logic [CONVEYOR_ADDR_WIDTH-1:0] out_slot_q, out_slot_d;
    logic [WORD_WIDTH-1:0]          out_value_q, out_value_d;
    logic [FAULT_ADDR_WIDTH-1:0]    out_fault;
    logic                           wr_en, can_load, xfer;

    conveyor_rr_pick #(.N(REQUESTERS)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        wr_en          = out_valid_q && !bus.port_busy[out_conveyor_q];
        can_load       = !out_valid_q || wr_en;
        xfer           = can_load && pick_any;
        out_valid_d    = xfer ? 1'b1 : (wr_en ? 1'b0 : out_valid_q);
        out_conveyor_d = xfer ? bus.req_conveyor[pick_idx] : out_conveyor_q;
        out_slot_d     = xfer ? bus.req_slot[pick_idx] : out_slot_q;
        out_value_d    = xfer ? bus.req_value[pick_idx] : out_value_q;
        rr_ptr_d       = !xfer ? rr_ptr_q : (int'(pick_idx) == REQUESTERS - 1) ? '0 : pick_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q       <= '0;
            out_valid_q    <= 1'b0;
            out_conveyor_q <= 1'b0;
            out_slot_q     <= '0;
            out_value_q    <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            out_valid_q    <= out_valid_d;
            out_conveyor_q <= out_conveyor_d;
            out_slot_q     <= out_slot_d;
            out_value_q    <= out_value_d;
        end
    end

`ifdef CONVEYOR_ARB_FAULT_EN
    logic [FAULT_ADDR_WIDTH-1:0] out_fault_q, out_fault_d;
    assign out_fault_d = xfer ? bus.req_fault[pick_idx] : out_fault_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_fault_q <= F_NONE;
        else        out_fault_q <= out_fault_d;
    end
    assign out_fault = out_fault_q;
`else
    logic unused_fault;
    assign unused_fault = ^bus.req_fault;
    assign out_fault = F_NONE;
`endif

    assign bus.req_ready   = can_load ? pick_grant : '0;
    assign bus.wr_en       = wr_en;
    assign bus.wr_conveyor = out_conveyor_q;
    assign bus.wr_slot     = out_slot_q;
    assign bus.wr_data     = out_valid_q ? {1'b1, out_fault, out_value_q} : '0;
    assign bus.idle        = !out_valid_q && !(|bus.req_valid);
endmodule

// File: doc/conveyor_write_arbiter.md
# conveyor_write_arbiter

Shares the single result-write port of the two conveyors (main and interrupt) among REQUESTERS pipelines that complete out of order. Each requester presents a finished value and fault for a previously reserved slot. The block picks one per cycle by round-robin and registers it into a one-entry output stage. That stage yields to the load/interrupt write path through per-conveyor `port_busy`, so no write is ever dropped.

## Interface
- WORD_WIDTH, 32, conveyor data word width
- CONVEYOR_ADDR_WIDTH, 4, conveyor slot index width (16 slots)
- REQUESTERS, 4, number of pipeline write requesters (≥2)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  REQUESTERS  requester i holds a completed result
- req_ready  output  REQUESTERS  one-hot-or-zero grant; transfer when valid&ready
- req_conveyor  input  REQUESTERS×1  target conveyor, 0 main, 1 interrupt
- req_slot  input  REQUESTERS×CONVEYOR_ADDR_WIDTH  target slot index
- req_value  input  REQUESTERS×WORD_WIDTH  result word
- req_fault  input  REQUESTERS×FAULT_ADDR_WIDTH  fault code for the slot
- port_busy  input  2  conveyor write port taken this cycle by load/interrupt path
- wr_en  output  1  write strobe to conveyor storage
- wr_conveyor  output  1  conveyor written
- wr_slot  output  CONVEYOR_ADDR_WIDTH  slot written
- wr_data  output  CONVEYOR_WIDTH  {finished=1, fault, value}
- idle  output  1  output stage empty and no req_valid asserted

## Operation
- State: round-robin pointer `rr_ptr` (log2 REQUESTERS bits); output stage `out_valid` + captured {conveyor, slot, fault, value}.
- wr_en = out_valid && !port_busy[out_conveyor]; wr_* driven from the output stage.
- Stage can load when !out_valid or wr_en (drain and refill same cycle).
- When the stage can load: grant the first valid requester at or after rr_ptr, cyclically. req_ready is high for that index only. Otherwise all req_ready are 0.
- On transfer of requester g: stage captures its fields; rr_ptr <= (g+1) mod REQUESTERS.
- No grant: rr_ptr is unchanged.
- Blocked stage (out_valid && port_busy[out_conveyor]): contents held, no grants, rr_ptr held.
- port_busy of the other conveyor does not block.
- Same-slot writes from different requesters are serialized; the later write wins. No merging or checking.
- No starvation: a continuously valid requester is granted within REQUESTERS accepted transfers.
- req_ready depends combinationally on req_valid; requesters must not derive valid from ready.
- Widths: CONVEYOR_WIDTH = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH. wr_data MSB is finished, always 1 when wr_en.

## Timing
- Reset (async assert, sync release): out_valid=0, rr_ptr=0, wr_en=0, wr_conveyor=0, wr_slot=0, wr_data=0, req_ready=0, idle=1 once inputs are quiet.
- Reset mid-operation discards the held entry; requesters must re-present.
- Latency: transfer in cycle t gives wr_en in t+1 if port_busy is clear, otherwise the first later cycle with port_busy clear.
- Throughput: one write per cycle while port_busy stays clear.
- port_busy is combinational into wr_en and req_ready, with no added cycle.

## Configuration
- CONVEYOR_ARB_FAULT_EN defined: req_fault is captured and written into the wr_data fault field.
- Undefined: req_fault is ignored, the fault field is F_NONE, and no fault flops exist.

## Structure
- Shared package conveyor_pkg holds:
  - FAULT_ADDR_WIDTH, F_NONE and the fault code constants
  - the CONVEYOR_WIDTH function of WORD_WIDTH
  - a conveyor_slot_t struct {finished, fault, value}
- One sub-module, conveyor_rr_pick: combinational rotate-priority picker (valid vector, pointer → one-hot grant, index, any). Pointer and stage stay in the parent.

## Test plan
- Reset: assert reset low with out_valid=1 → wr_en=0 and rr_ptr=0 immediately; all outputs zero after release.
- Single request: req 2 valid, conveyor 0, slot 5, value 0xDEADBEEF, fault 0 → ready[2] in t; in t+1, wr_en=1, slot 5, wr_data={1,F_NONE,0xDEADBEEF}.
- Round-robin: all four valid continuously, rr_ptr=0 → grants 0,1,2,3,0, one per cycle, back-to-back wr_en.
- Port blocking:
  - stage holds a conveyor 1 write and port_busy=2'b10 for 3 cycles → wr_en=0 and ready=0 for those cycles; the write issues on cycle 4.
  - port_busy=2'b01 at the same time → no effect on that write.
- Fault passthrough with CONVEYOR_ARB_FAULT_EN, req_fault=3 → wr_data fault field=3. Macro undefined → F_NONE.
- Same slot: req 0 and req 1 both target conveyor 0 slot 7, values 1 and 2, rr_ptr=0 → two writes in order 1 then 2.
